// File: rtl/dbus_if.sv
// dbus_if: Avalon-MM data bus request/response bundle shared by the LSU, the decoder and its slaves
interface dbus_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    modport master (output read, write, address, writedata, byte_enable,
                    input  readdata, readdatavalid, waitrequest);
    modport slave  (input  read, write, address, writedata, byte_enable,
                    output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/dbus_decoder.sv
// dbus_decoder: routes LSU Avalon-MM requests to data RAM / MMIO and returns read responses in order
module dbus_decoder #(
    parameter logic [31:0] S0_BASE       = 32'h0000_0000,
    parameter logic [31:0] S0_MASK       = 32'hF000_0000,
    parameter logic [31:0] S1_BASE       = 32'h8000_0000,
    parameter logic [31:0] S1_MASK       = 32'hF000_0000,
    parameter int          MAX_OUTST     = 4,
    parameter logic [31:0] UNMAPPED_DATA = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst,
    dbus_if.slave  m,
    dbus_if.master s0,
    dbus_if.master s1,
    output logic   bus_error_load,
    output logic   bus_error_store
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    typedef enum logic [1:0] {SEL_NONE, SEL_S0, SEL_S1} sel_t;
    sel_t          sel, pend_sel;
    logic [CW-1:0] cnt;
    logic          un_valid, req, block, acc_rd, acc_wr, src_valid;
    logic [31:0]   src_data;
    // A request to a different target than the pending reads must wait so responses stay in order
    always_comb begin
        sel = ((m.address & S0_MASK) == S0_BASE) ? SEL_S0 :
              ((m.address & S1_MASK) == S1_BASE) ? SEL_S1 : SEL_NONE;
        req = m.read | m.write;
        block = (m.read && cnt == CW'(MAX_OUTST)) || (req && cnt != '0 && sel != pend_sel);
        m.waitrequest = block | (sel == SEL_S0 ? s0.waitrequest :
                                 sel == SEL_S1 ? s1.waitrequest : 1'b0);
        acc_rd = m.read & ~m.waitrequest;
        acc_wr = m.write & ~m.waitrequest;
        s0.address = m.address;
        s0.writedata = m.writedata;
        s0.byte_enable = m.byte_enable;
        s1.address = m.address;
        s1.writedata = m.writedata;
        s1.byte_enable = m.byte_enable;
        s0.read = m.read && sel == SEL_S0 && !block;
        s0.write = m.write && sel == SEL_S0 && !block;
        s1.read = m.read && sel == SEL_S1 && !block;
        s1.write = m.write && sel == SEL_S1 && !block;
        src_valid = pend_sel == SEL_S0 ? s0.readdatavalid :
                    pend_sel == SEL_S1 ? s1.readdatavalid : un_valid;
        src_data = pend_sel == SEL_S0 ? s0.readdata :
                   pend_sel == SEL_S1 ? s1.readdata : UNMAPPED_DATA;
        m.readdatavalid = src_valid && cnt != '0;
        m.readdata = src_data;
        bus_error_load = m.readdatavalid && pend_sel == SEL_NONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pend_sel <= SEL_NONE;
            un_valid <= 1'b0;
            bus_error_store <= 1'b0;
        end else begin
            cnt <= cnt + CW'(acc_rd) - CW'(m.readdatavalid);
            pend_sel <= acc_rd ? sel : pend_sel;
            un_valid <= acc_rd && sel == SEL_NONE;
            bus_error_store <= acc_wr && sel == SEL_NONE;
        end
    end
endmodule

// File: tb/tb_dbus_decoder.sv
// tb_dbus_decoder: directed-vector bench for dbus_decoder with hand-computed expectations
module tb_dbus_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_error_load, bus_error_store;
    int   n_chk = 0;
    int   n_pass = 0;

    dbus_if m_if();
    dbus_if s0_if();
    dbus_if s1_if();

    dbus_decoder dut (
        .clk(clk), .rst(rst), .m(m_if), .s0(s0_if), .s1(s1_if),
        .bus_error_load(bus_error_load), .bus_error_store(bus_error_store)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle();
        m_if.read = 1'b0;
        m_if.write = 1'b0;
    endtask

    // Back-to-back S0 reads, first response four cycles after the first accept
    logic       t2_rd   [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic       t2_wait [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic       t2_rdv  [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0};
    logic [2:0] t2_cnt  [11] = '{0, 1, 2, 3, 4, 3, 3, 2, 1, 1, 0};

    initial begin
        idle();
        m_if.address = '0;
        m_if.writedata = '0;
        m_if.byte_enable = 4'hF;
        s0_if.readdata = '0;
        s0_if.readdatavalid = 1'b0;
        s0_if.waitrequest = 1'b0;
        s1_if.readdata = '0;
        s1_if.readdatavalid = 1'b0;
        s1_if.waitrequest = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        look();
        chk("rst_rdv", 32'(m_if.readdatavalid), 0);
        chk("rst_cnt", 32'(dut.cnt), 0);
        chk("rst_bel", 32'(bus_error_load), 0);
        chk("rst_bes", 32'(bus_error_store), 0);
        chk("rst_s0rd", 32'(s0_if.read), 0);
        chk("rst_s1rd", 32'(s1_if.read), 0);

        cyc();
        m_if.read = 1'b1;
        m_if.address = 32'h0000_0010;
        look();
        chk("t1_s0rd", 32'(s0_if.read), 1);
        chk("t1_s1rd", 32'(s1_if.read), 0);
        chk("t1_wait", 32'(m_if.waitrequest), 0);
        cyc();
        idle();
        s0_if.readdatavalid = 1'b1;
        s0_if.readdata = 32'h1234_5678;
        look();
        chk("t1_rdv", 32'(m_if.readdatavalid), 1);
        chk("t1_data", m_if.readdata, 32'h1234_5678);
        chk("t1_cnt1", 32'(dut.cnt), 1);
        cyc();
        s0_if.readdatavalid = 1'b0;
        look();
        chk("t1_cnt0", 32'(dut.cnt), 0);
        chk("t1_rdv0", 32'(m_if.readdatavalid), 0);

        for (int i = 0; i < 11; i++) begin
            cyc();
            m_if.read = t2_rd[i];
            m_if.address = 32'h100 + 32'(4 * i);
            s0_if.readdatavalid = t2_rdv[i];
            s0_if.readdata = 32'hA0 + 32'(i);
            look();
            chk($sformatf("t2_cnt%0d", i), 32'(dut.cnt), 32'(t2_cnt[i]));
            chk($sformatf("t2_rdv%0d", i), 32'(m_if.readdatavalid), 32'(t2_rdv[i]));
            if (t2_rd[i]) begin
                chk($sformatf("t2_wait%0d", i), 32'(m_if.waitrequest), 32'(t2_wait[i]));
                chk($sformatf("t2_s0rd%0d", i), 32'(s0_if.read), 32'(!t2_wait[i]));
            end
            if (t2_rdv[i]) chk($sformatf("t2_data%0d", i), m_if.readdata, 32'hA0 + 32'(i));
        end

        cyc();
        s0_if.readdatavalid = 1'b0;
        m_if.read = 1'b1;
        m_if.address = 32'h8000_0004;
        look();
        chk("t3_s1rd", 32'(s1_if.read), 1);
        chk("t3_s0rd_a", 32'(s0_if.read), 0);
        chk("t3_wait_a", 32'(m_if.waitrequest), 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            m_if.address = 32'h0000_0020;
            look();
            chk($sformatf("t3_blk%0d", i), 32'(m_if.waitrequest), 1);
            chk($sformatf("t3_s0rd%0d", i), 32'(s0_if.read), 0);
        end
        cyc();
        s1_if.readdatavalid = 1'b1;
        s1_if.readdata = 32'hCAFE_0001;
        look();
        chk("t3_rdv", 32'(m_if.readdatavalid), 1);
        chk("t3_data", m_if.readdata, 32'hCAFE_0001);
        chk("t3_blk_last", 32'(m_if.waitrequest), 1);
        chk("t3_s0rd_last", 32'(s0_if.read), 0);
        cyc();
        s1_if.readdatavalid = 1'b0;
        look();
        chk("t3_wait_go", 32'(m_if.waitrequest), 0);
        chk("t3_s0rd_go", 32'(s0_if.read), 1);
        cyc();
        idle();
        s0_if.readdatavalid = 1'b1;
        s0_if.readdata = 32'h0000_0055;
        look();
        chk("t3_s0rdv", 32'(m_if.readdatavalid), 1);
        chk("t3_s0data", m_if.readdata, 32'h0000_0055);
        cyc();
        s0_if.readdatavalid = 1'b0;
        s0_if.readdata = 32'hDEAD_BEEF;
        m_if.read = 1'b1;
        m_if.address = 32'h4000_0000;
        look();
        chk("t4_wait", 32'(m_if.waitrequest), 0);
        chk("t4_s0rd", 32'(s0_if.read), 0);
        chk("t4_s1rd", 32'(s1_if.read), 0);
        chk("t4_bel_pre", 32'(bus_error_load), 0);
        cyc();
        idle();
        look();
        chk("t4_rdv", 32'(m_if.readdatavalid), 1);
        chk("t4_data", m_if.readdata, 32'h0);
        chk("t4_bel", 32'(bus_error_load), 1);
        cyc();
        look();
        chk("t4_rdv_off", 32'(m_if.readdatavalid), 0);
        chk("t4_bel_off", 32'(bus_error_load), 0);
        chk("t4_cnt", 32'(dut.cnt), 0);

        cyc();
        m_if.write = 1'b1;
        m_if.address = 32'h4000_0000;
        m_if.writedata = 32'h1111_2222;
        look();
        chk("t5_wait_un", 32'(m_if.waitrequest), 0);
        chk("t5_s0wr_un", 32'(s0_if.write), 0);
        chk("t5_s1wr_un", 32'(s1_if.write), 0);
        chk("t5_bes_pre", 32'(bus_error_store), 0);
        cyc();
        m_if.address = 32'h0000_0030;
        s0_if.waitrequest = 1'b1;
        look();
        chk("t5_bes", 32'(bus_error_store), 1);
        chk("t5_wait0", 32'(m_if.waitrequest), 1);
        chk("t5_s0wr", 32'(s0_if.write), 1);
        chk("t5_wdata", s0_if.writedata, 32'h1111_2222);
        cyc();
        look();
        chk("t5_bes_off", 32'(bus_error_store), 0);
        chk("t5_wait1", 32'(m_if.waitrequest), 1);
        cyc();
        s0_if.waitrequest = 1'b0;
        look();
        chk("t5_wait_rel", 32'(m_if.waitrequest), 0);
        cyc();
        idle();
        look();
        chk("t5_bes_s0", 32'(bus_error_store), 0);
        chk("t5_cnt", 32'(dut.cnt), 0);

        cyc();
        m_if.read = 1'b1;
        m_if.address = 32'h0000_0040;
        cyc();
        m_if.address = 32'h0000_0044;
        cyc();
        idle();
        rst = 1'b1;
        look();
        chk("t6_cnt_pre", 32'(dut.cnt), 2);
        cyc();
        rst = 1'b0;
        s0_if.readdatavalid = 1'b1;
        s0_if.readdata = 32'h7777_7777;
        for (int i = 0; i < 2; i++) begin
            look();
            chk($sformatf("t6_rdv%0d", i), 32'(m_if.readdatavalid), 0);
            chk($sformatf("t6_cnt%0d", i), 32'(dut.cnt), 0);
            cyc();
        end
        s0_if.readdatavalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
